dcm_lock_ctrl: RTL and testbench

//  Sequencer for the DCM-based clock generator (ck_div). Pulses DCM RST, waits for LOCKED

---
 rtl/dcm_lock_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dcm_lock_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_ctrl.sv
// DCM lock sequencer: pulses DCM RST, waits for LOCKED with timeout and retry, then
// releases the downstream reset. Optional STATUS monitoring under `DCM_CTRL_STATUS_EN.
module dcm_lock_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       ck_in,
    input  logic       sys_rst_i,
    input  logic       dcm_locked_i,
    input  logic [2:0] dcm_status_i,
    input  logic       relock_req_i,
    output logic       dcm_rst_o,
    output logic       rst_out_n_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        ST_RST_PULSE,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retryCnt;
    logic             r_dcmRst;
    logic             r_rstOutN;
    logic             r_ready;
    logic             r_fail;
    logic             r_lockMeta;
    logic             r_lockSync;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [3:0]       w_retryNext;
    logic [3:0]       w_retryInc;
    logic             w_dcmRstNext;
    logic             w_rstOutNNext;
    logic             w_readyNext;
    logic             w_failNext;
    logic             w_clkStopped;
    logic             w_lockGood;
    logic             w_unusedStatus;

    always_ff @(posedge ck_in or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_lockMeta <= 1'b0;
            r_lockSync <= 1'b0;
        end else begin
            r_lockMeta <= dcm_locked_i;
            r_lockSync <= r_lockMeta;
        end
    end

`ifdef DCM_CTRL_STATUS_EN
    // Only CLKIN-stopped [1] and CLKFX-stopped [2] matter; phase overflow [0] is ignored.
    logic [1:0] r_statMeta;
    logic [1:0] r_statSync;

    always_ff @(posedge ck_in or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_statMeta <= 2'b00;
            r_statSync <= 2'b00;
        end else begin
            r_statMeta <= dcm_status_i[2:1];
            r_statSync <= r_statMeta;
        end
    end

    assign w_clkStopped   = |r_statSync;
    assign w_unusedStatus = dcm_status_i[0];
`else
    assign w_clkStopped   = 1'b0;
    assign w_unusedStatus = ^dcm_status_i;
`endif

    assign w_lockGood = r_lockSync & ~w_clkStopped;
    assign w_cntInc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_retryInc = r_retryCnt + 4'd1;

    always_ff @(posedge ck_in or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_state    <= ST_RST_PULSE;
            r_cnt      <= '0;
            r_retryCnt <= 4'd0;
            r_dcmRst   <= 1'b1;
            r_rstOutN  <= 1'b0;
            r_ready    <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_retryCnt <= w_retryNext;
            r_dcmRst   <= w_dcmRstNext;
            r_rstOutN  <= w_rstOutNNext;
            r_ready    <= w_readyNext;
            r_fail     <= w_failNext;
        end
    end

    // Relock request overrides every other transition in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_retryNext = r_retryCnt;
        if (relock_req_i) begin
            w_stateNext = ST_RST_PULSE;
            w_cntNext   = '0;
            w_retryNext = 4'd0;
        end else begin
            case (r_state)
                ST_RST_PULSE: begin
                    if (r_cnt >= RST_LAST) begin
                        w_stateNext = ST_WAIT_LOCK;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lockSync) begin
                        w_stateNext = ST_STABLE;
                        w_cntNext   = '0;
                    end else if (r_cnt >= TIMEOUT_LAST) begin
                        w_retryNext = w_retryInc;
                        w_cntNext   = '0;
                        w_stateNext = (w_retryInc == RETRY_LIMIT) ? ST_FAIL : ST_RST_PULSE;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                ST_STABLE: begin
                    if (!w_lockGood) begin
                        w_stateNext = ST_WAIT_LOCK;
                        w_cntNext   = '0;
                    end else if (r_cnt >= STABLE_LAST) begin
                        w_stateNext = ST_RUN;
                        w_cntNext   = '0;
                        w_retryNext = 4'd0;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                ST_RUN: begin
                    if (!w_lockGood) begin
                        w_stateNext = ST_RST_PULSE;
                        w_cntNext   = '0;
                    end
                end
                ST_FAIL: begin
                    w_stateNext = ST_FAIL;
                end
                default: begin
                    w_stateNext = ST_RST_PULSE;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change with the state.
    always_comb begin
        w_dcmRstNext  = (w_stateNext == ST_RST_PULSE) || (w_stateNext == ST_FAIL);
        w_rstOutNNext = (w_stateNext == ST_RUN);
        w_readyNext   = (w_stateNext == ST_RUN);
        w_failNext    = (w_stateNext == ST_FAIL);
    end

    assign dcm_rst_o   = r_dcmRst;
    assign rst_out_n_o = r_rstOutN;
    assign ready_o     = r_ready;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retryCnt;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Directed bench for dcm_lock_ctrl; expected outputs are packed as
// {dcm_rst, rst_out_n, ready, fail, retry_cnt[3:0]}.
module tb_dcm_lock_ctrl;

    logic       ck_in;
    logic       sysRst;
    logic       locked;
    logic [2:0] status;
    logic       relock;
    logic       dcmRst;
    logic       rstOutN;
    logic       ready;
    logic       fail;
    logic [3:0] retryCnt;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

`ifdef DCM_CTRL_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    dcm_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2),
        .CNT_W        (16)
    ) dut (
        .ck_in       (ck_in),
        .sys_rst_i   (sysRst),
        .dcm_locked_i(locked),
        .dcm_status_i(status),
        .relock_req_i(relock),
        .dcm_rst_o   (dcmRst),
        .rst_out_n_o (rstOutN),
        .ready_o     (ready),
        .fail_o      (fail),
        .retry_cnt_o (retryCnt)
    );

    assign obs = {dcmRst, rstOutN, ready, fail, retryCnt};

    initial ck_in = 1'b0;
    always #5 ck_in = ~ck_in;

    task automatic tick(input int n);
        repeat (n) @(posedge ck_in);
        #1;
    endtask

    task automatic test_reset;
        sysRst = 1'b1; locked = 1'b0; status = 3'b000; relock = 1'b0;
        #1 sysRst = 1'b0;
        #1;
        if (obs !== 8'h80) begin $display("[TB] FAIL reset_async: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(2);
        if (obs !== 8'h80) begin $display("[TB] FAIL reset_hold: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        sysRst = 1'b1;
    endtask

    task automatic test_bringup;
        tick(3);
        if (obs !== 8'h80) begin $display("[TB] FAIL bringup_pulse: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h00) begin $display("[TB] FAIL bringup_pulse_end: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(5);
        locked = 1'b1;
        tick(10);
        if (obs !== 8'h00) begin $display("[TB] FAIL bringup_early: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL bringup_run: got %h expected %h", obs, 8'h60); bad++; end
        total++;
    endtask

    task automatic test_run_lock_loss;
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL loss_sync_delay: got %h expected %h", obs, 8'h60); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h80) begin $display("[TB] FAIL loss_reset: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(3);
        if (obs !== 8'h80) begin $display("[TB] FAIL loss_pulse_hold: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h00) begin $display("[TB] FAIL loss_pulse_end: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(8);
        if (obs !== 8'h00) begin $display("[TB] FAIL loss_restable: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL loss_rerun: got %h expected %h", obs, 8'h60); bad++; end
        total++;
    endtask

    task automatic test_stable_glitch;
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        if (obs !== 8'h80) begin $display("[TB] FAIL relock_in_run: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(5);
        if (obs !== 8'h00) begin $display("[TB] FAIL glitch_stable_entry: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(2);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        for (int i = 10; i <= 19; i++) begin
            tick(1);
            if (obs !== 8'h00) begin
                $display("[TB] FAIL glitch_cycle_%0d: got %h expected %h", i, obs, 8'h00); bad++;
            end
            total++;
        end
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL glitch_run: got %h expected %h", obs, 8'h60); bad++; end
        total++;
    endtask

    task automatic test_timeout_fail;
        locked = 1'b0;
        tick(3);
        if (obs !== 8'h80) begin $display("[TB] FAIL to_run_loss: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(4);
        if (obs !== 8'h00) begin $display("[TB] FAIL to_wait1: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(19);
        if (obs !== 8'h00) begin $display("[TB] FAIL to_wait1_last: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h81) begin $display("[TB] FAIL to_retry1: got %h expected %h", obs, 8'h81); bad++; end
        total++;
        tick(3);
        if (obs !== 8'h81) begin $display("[TB] FAIL to_retry1_pulse: got %h expected %h", obs, 8'h81); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h01) begin $display("[TB] FAIL to_wait2: got %h expected %h", obs, 8'h01); bad++; end
        total++;
        tick(19);
        if (obs !== 8'h01) begin $display("[TB] FAIL to_wait2_last: got %h expected %h", obs, 8'h01); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h92) begin $display("[TB] FAIL to_fail: got %h expected %h", obs, 8'h92); bad++; end
        total++;
        tick(30);
        if (obs !== 8'h92) begin $display("[TB] FAIL to_fail_hold: got %h expected %h", obs, 8'h92); bad++; end
        total++;
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        locked = 1'b1;
        if (obs !== 8'h80) begin $display("[TB] FAIL to_relock: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        tick(4);
        if (obs !== 8'h00) begin $display("[TB] FAIL to_relock_wait: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(8);
        if (obs !== 8'h00) begin $display("[TB] FAIL to_relock_stable: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL to_relock_run: got %h expected %h", obs, 8'h60); bad++; end
        total++;
    endtask

    task automatic test_async_reset;
        #3 sysRst = 1'b0;
        #1;
        if (obs !== 8'h80) begin $display("[TB] FAIL async_rst_run: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        #2 sysRst = 1'b1;
        tick(7);
        if (obs !== 8'h00) begin $display("[TB] FAIL async_pre_stable: got %h expected %h", obs, 8'h00); bad++; end
        total++;
        #3 sysRst = 1'b0;
        #1;
        if (obs !== 8'h80) begin $display("[TB] FAIL async_rst_stable: got %h expected %h", obs, 8'h80); bad++; end
        total++;
        #2 sysRst = 1'b1;
        tick(1);
    endtask

    task automatic test_status;
        tick(12);
        if (obs !== 8'h60) begin $display("[TB] FAIL status_run: got %h expected %h", obs, 8'h60); bad++; end
        total++;
        status = 3'b001;
        tick(4);
        if (obs !== 8'h60) begin $display("[TB] FAIL status_bit0_ignored: got %h expected %h", obs, 8'h60); bad++; end
        total++;
        status = 3'b010;
        tick(1);
        status = 3'b000;
        tick(1);
        if (obs !== 8'h60) begin $display("[TB] FAIL status_sync_delay: got %h expected %h", obs, 8'h60); bad++; end
        total++;
        tick(1);
        if (obs !== (STATUS_EN ? 8'h80 : 8'h60)) begin
            $display("[TB] FAIL status_response: got %h expected %h", obs, STATUS_EN ? 8'h80 : 8'h60); bad++;
        end
        total++;
        tick(4);
        if (obs !== (STATUS_EN ? 8'h00 : 8'h60)) begin
            $display("[TB] FAIL status_pulse_end: got %h expected %h", obs, STATUS_EN ? 8'h00 : 8'h60); bad++;
        end
        total++;
        tick(9);
        if (obs !== 8'h60) begin $display("[TB] FAIL status_rerun: got %h expected %h", obs, 8'h60); bad++; end
        total++;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_run_lock_loss();
        test_stable_glitch();
        test_timeout_fail();
        test_async_reset();
        test_status();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
